// File: rtl/dmem_lsu_pkg.sv
// Shared encodings and helpers for the data-memory load/store unit.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_BAD = 2'b11
  } size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Number of bytes touched by an access of the given size (0 for the illegal code).
  function automatic logic [2:0] size_bytes(size_e size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Lanes touched by an access: the contiguous byte mask rotated up by the byte offset.
  function automatic logic [3:0] lane_mask(size_e size, logic [1:0] off);
    logic [3:0] base;
    logic [7:0] doubled;
    case (size)
      SIZE_B:  base = 4'b0001;
      SIZE_H:  base = 4'b0011;
      SIZE_W:  base = 4'b1111;
      default: base = 4'b0000;
    endcase
    doubled = {base, base} << off;
    return doubled[7:4];
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core-side request/response bus of the load/store unit.
interface dmem_lsu_if #(
  parameter int ADDR_WIDTH = 13
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [31:0]           rsp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface

// File: rtl/dmem_lsu_lane_rotate.sv
// Byte rotator between access byte order and lane order.
// GATHER=0 scatters access byte k onto lane (off+k) mod 4 (stores);
// GATHER=1 pulls lane (off+k) mod 4 back into byte k (loads).
module dmem_lane_rotate #(
  parameter bit GATHER = 1'b0
) (
  input  logic [31:0] data,
  input  logic [1:0]  off,
  output logic [31:0] rotated
);

  // Pure byte rotation; the two directions only differ for offsets 1 and 3.
  always_comb begin
    rotated = data;
    case (off)
      2'd1:    rotated = GATHER ? {data[7:0], data[31:8]}   : {data[23:0], data[31:24]};
      2'd2:    rotated = {data[15:0], data[31:16]};
      2'd3:    rotated = GATHER ? {data[23:0], data[31:24]} : {data[7:0], data[31:8]};
      default: rotated = data;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store front end for a data memory made of four byte-lane BRAMs.
// One request is in flight at a time: accept in IDLE, lanes strobed for one
// cycle in ACCESS, response pulses on the edge that returns to IDLE.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH       = 13,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dmem_lsu_if.slave               bus,
  output logic [4*ADDR_WIDTH-1:0] mem_r_addr,
  output logic [4*ADDR_WIDTH-1:0] mem_w_addr,
  output logic [3:0]              mem_re,
  output logic [3:0]              mem_we,
  output logic [31:0]             mem_din,
  input  logic [31:0]             mem_dout
);

  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [WW-1:0] W_ONE = WW'(1);
  localparam logic [WW-1:0] W_MAX = '1;

  state_e state_q, state_d;

  logic [1:0] off_q, off_d;
  size_e      size_q, size_d;
  logic       uns_q, uns_d;
  logic       we_q, we_d;
  logic       err_q, err_d;

  logic                    req_ready_d;
  logic                    rsp_valid_d;
  logic                    rsp_err_d;
  logic [31:0]             rsp_rdata_d;
  logic [3:0]              mem_re_d;
  logic [3:0]              mem_we_d;
  logic [4*ADDR_WIDTH-1:0] mem_r_addr_d;
  logic [4*ADDR_WIDTH-1:0] mem_w_addr_d;
  logic [31:0]             mem_din_d;

  logic                    accept;
  size_e                   req_size;
  logic [1:0]              off;
  logic [WW-1:0]           w_lo;
  logic [WW-1:0]           w_hi;
  logic [3:0]              end_byte;
  logic                    straddle;
  logic                    misaligned;
  logic                    req_err;
  logic [3:0]              used_lanes;
  logic [31:0]             byte_mask;
  logic [4*ADDR_WIDTH-1:0] lane_addr;
  logic [31:0]             store_lanes;
  logic [31:0]             load_gather;
  logic [31:0]             load_fmt;
  logic                    fill_bit;

  assign accept = bus.req_valid & bus.req_ready;

  dmem_lane_rotate #(.GATHER(1'b0)) u_scatter (
    .data    (bus.req_wdata),
    .off     (off),
    .rotated (store_lanes)
  );

  dmem_lane_rotate #(.GATHER(1'b1)) u_gather (
    .data    (mem_dout),
    .off     (off_q),
    .rotated (load_gather)
  );

  // Decode the incoming request: lanes used, per-lane word address and error causes.
  always_comb begin
    req_size   = size_e'(bus.req_size);
    off        = bus.req_addr[1:0];
    w_lo       = bus.req_addr[ADDR_WIDTH-1:2];
    w_hi       = w_lo + W_ONE;
    end_byte   = {2'b00, off} + {1'b0, size_bytes(req_size)};
    straddle   = end_byte > 4'd4;
    used_lanes = lane_mask(req_size, off);
    misaligned = !ALLOW_MISALIGNED &&
                 (((req_size == SIZE_H) && off[0]) ||
                  ((req_size == SIZE_W) && (off != 2'b00)));
    req_err    = (req_size == SIZE_BAD) || misaligned || (straddle && (w_lo == W_MAX));
    byte_mask  = '0;
    lane_addr  = '0;
    for (int l = 0; l < 4; l++) begin
      byte_mask[l*8 +: 8] = {8{used_lanes[l]}};
      if (used_lanes[l]) begin
        lane_addr[l*ADDR_WIDTH +: ADDR_WIDTH] = {((l < int'(off)) ? w_hi : w_lo), 2'b00};
      end
    end
  end

  // Sign- or zero-extend the gathered load bytes above the access width.
  always_comb begin
    load_fmt = load_gather;
    fill_bit = 1'b0;
    case (size_q)
      SIZE_B: begin
        fill_bit       = !uns_q && load_gather[7];
        load_fmt[31:8] = {24{fill_bit}};
      end
      SIZE_H: begin
        fill_bit        = !uns_q && load_gather[15];
        load_fmt[31:16] = {16{fill_bit}};
      end
      default: load_fmt = load_gather;
    endcase
  end

  // Next state: a single ACCESS cycle follows every accepted request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next output values: lane strobes on accept, response during ACCESS.
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_rdata_d  = '0;
    mem_re_d     = '0;
    mem_we_d     = '0;
    mem_r_addr_d = '0;
    mem_w_addr_d = '0;
    mem_din_d    = '0;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    we_d         = we_q;
    err_d        = err_q;
    if ((state_q == IDLE) && accept) begin
      off_d  = off;
      size_d = req_size;
      uns_d  = bus.req_unsigned;
      we_d   = bus.req_we;
      err_d  = req_err;
      if (!req_err) begin
        if (bus.req_we) begin
          mem_we_d     = used_lanes;
          mem_w_addr_d = lane_addr;
          mem_din_d    = store_lanes & byte_mask;
        end else begin
          mem_re_d     = used_lanes;
          mem_r_addr_d = lane_addr;
        end
      end
    end
    if (state_q == ACCESS) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_q;
      rsp_rdata_d = (err_q || we_q) ? 32'h0 : load_fmt;
    end
  end

  // State and every output are registered; reset clears them immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      off_q         <= '0;
      size_q        <= SIZE_B;
      uns_q         <= 1'b0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      mem_re        <= '0;
      mem_we        <= '0;
      mem_r_addr    <= '0;
      mem_w_addr    <= '0;
      mem_din       <= '0;
    end else begin
      state_q       <= state_d;
      off_q         <= off_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      we_q          <= we_d;
      err_q         <= err_d;
      bus.req_ready <= req_ready_d;
      bus.rsp_valid <= rsp_valid_d;
      bus.rsp_err   <= rsp_err_d;
      bus.rsp_rdata <= rsp_rdata_d;
      mem_re        <= mem_re_d;
      mem_we        <= mem_we_d;
      mem_r_addr    <= mem_r_addr_d;
      mem_w_addr    <= mem_w_addr_d;
      mem_din       <= mem_din_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: four byte-lane memories plus a flat byte-array
// reference model of the memory contents and expected lane activity.
module tb_dmem_lsu;

  localparam int AW        = 13;
  localparam int MEM_BYTES = 1 << AW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4*AW-1:0] mem_r_addr;
  logic [4*AW-1:0] mem_w_addr;
  logic [3:0]      mem_re;
  logic [3:0]      mem_we;
  logic [31:0]     mem_din;
  logic [31:0]     mem_dout = '0;
  bit              mem_init_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] lane_mem [4][MEM_BYTES/4];
  logic [7:0] ref_mem  [MEM_BYTES];

  logic            exp_err;
  logic [31:0]     exp_rdata;
  logic [3:0]      exp_we;
  logic [3:0]      exp_re;
  logic [4*AW-1:0] exp_waddr;
  logic [4*AW-1:0] exp_raddr;
  logic [31:0]     exp_din;

  dmem_lsu_if #(.ADDR_WIDTH(AW)) bus ();

  dmem_lsu #(.ADDR_WIDTH(AW), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .mem_r_addr (mem_r_addr),
    .mem_w_addr (mem_w_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  // Byte-lane BRAMs: act on the falling edge, read-before-write.
  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < MEM_BYTES/4; j++)
          lane_mem[i][j] <= 8'h00;
      mem_init_done <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mem_re[i]) mem_dout[i*8 +: 8] <= lane_mem[i][mem_r_addr[i*AW+2 +: AW-2]];
        if (mem_we[i]) lane_mem[i][mem_w_addr[i*AW+2 +: AW-2]] <= mem_din[i*8 +: 8];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: byte-addressed view of the access, lanes derived from address mod 4.
  task automatic predict(input logic we, input logic [1:0] size, input logic uns,
                         input int addr, input logic [31:0] wdata);
    int n;
    int a;
    int lane;
    logic [31:0] v;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b10) ? 4 : 0;
    exp_err   = (n == 0) || (addr + n > MEM_BYTES);
    exp_we    = '0;
    exp_re    = '0;
    exp_waddr = '0;
    exp_raddr = '0;
    exp_din   = '0;
    v         = '0;
    if (!exp_err) begin
      for (int k = 0; k < n; k++) begin
        a    = addr + k;
        lane = a % 4;
        if (we) begin
          exp_we[lane]             = 1'b1;
          exp_waddr[lane*AW +: AW] = AW'(a & ~3);
          exp_din[lane*8 +: 8]     = wdata[k*8 +: 8];
        end else begin
          exp_re[lane]             = 1'b1;
          exp_raddr[lane*AW +: AW] = AW'(a & ~3);
          v[k*8 +: 8]              = ref_mem[a];
        end
      end
      if (!we)
        for (int k = n; k < 4; k++)
          v[k*8 +: 8] = (!uns && v[8*n-1]) ? 8'hFF : 8'h00;
    end
    exp_rdata = v;
  endtask

  // One request: drive, check lane activity after acceptance, check response one edge later.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input int addr, input logic [31:0] wdata, input bit keep_valid);
    int waited = 0;
    predict(we, size, uns, addr, wdata);
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (bus.req_ready !== 1'b1) begin
      checkOutput("ready_timeout", 64'(bus.req_ready), 64'd1);
      return;
    end
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = AW'(addr);
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_valid) bus.req_valid = 1'b0;
    checkOutput("ready_e0", 64'(bus.req_ready), 64'd0);
    checkOutput("rsp_valid_e0", 64'(bus.rsp_valid), 64'd0);
    checkOutput("mem_we", 64'(mem_we), 64'(exp_we));
    checkOutput("mem_re", 64'(mem_re), 64'(exp_re));
    checkOutput("mem_w_addr", 64'(mem_w_addr), 64'(exp_waddr));
    checkOutput("mem_r_addr", 64'(mem_r_addr), 64'(exp_raddr));
    checkOutput("mem_din", 64'(mem_din), 64'(exp_din));
    @(posedge clk);
    #1;
    checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    checkOutput("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
    checkOutput("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rdata));
    checkOutput("ready_e1", 64'(bus.req_ready), 64'd1);
    checkOutput("strobes_e1", 64'({mem_we, mem_re}), 64'd0);
    if (!exp_err && we) begin
      for (int k = 0; k < ((size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4); k++)
        ref_mem[addr + k] = wdata[k*8 +: 8];
    end
  endtask

  initial begin
    int addr;
    logic [1:0] size;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("rst_rsp", 64'({bus.rsp_valid, bus.rsp_err}), 64'd0);
    checkOutput("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    checkOutput("rst_strobes", 64'({mem_we, mem_re}), 64'd0);
    checkOutput("rst_addr", 64'(mem_r_addr | mem_w_addr), 64'd0);
    checkOutput("rst_din", 64'(mem_din), 64'd0);
    #2 rst_n = 1'b1;
    #1 checkOutput("ready_before_edge", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1 checkOutput("ready_after_release", 64'(bus.req_ready), 64'd1);

    // aligned word store/load
    applyStimulus(1'b1, 2'b10, 1'b0, 'h0010, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 'h0010, 32'h0, 1'b0);

    // byte loads with sign/zero extension
    applyStimulus(1'b1, 2'b10, 1'b0, 'h0020, 32'h80FF7F01, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 'h0023, 32'h0, 1'b0);
    checkOutput("lb_0x23_value", 64'(bus.rsp_rdata), 64'hFFFFFF80);
    applyStimulus(1'b0, 2'b00, 1'b1, 'h0023, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 'h0020, 32'h0, 1'b0);

    // straddling word store and the loads around it
    applyStimulus(1'b1, 2'b10, 1'b0, 'h0015, 32'h11223344, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 'h0014, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 'h0018, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 'h0015, 32'h0, 1'b0);
    checkOutput("lw_0x15_value", 64'(bus.rsp_rdata), 64'h11223344);

    // top of memory and illegal size
    applyStimulus(1'b0, 2'b01, 1'b0, 'h1FFE, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 'h1FFD, 32'h0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 'h1FFF, 32'hABCD, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b0, 'h0010, 32'h0, 1'b0);

    // back-to-back loads with REQ_VALID held high
    applyStimulus(1'b0, 2'b10, 1'b0, 'h0010, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 'h0023, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b10, 1'b0, 'h0014, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b01, 1'b1, 'h1FFE, 32'h0, 1'b1);
    bus.req_valid = 1'b0;

    // reset during a store's ACCESS cycle, before the lanes' falling edge
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = AW'('h0030);
    bus.req_wdata = 32'hCAFEF00D;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    checkOutput("abort_we_set", 64'(mem_we), 64'hF);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_we_clr", 64'(mem_we), 64'd0);
    checkOutput("abort_din_clr", 64'(mem_din), 64'd0);
    checkOutput("abort_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1 checkOutput("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
    #2 rst_n = 1'b1;
    #1 checkOutput("abort_no_rsp2", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk);
    #1 checkOutput("abort_ready_release", 64'(bus.req_ready), 64'd1);
    applyStimulus(1'b0, 2'b10, 1'b0, 'h0030, 32'h0, 1'b0);

    // randomized traffic near the bottom and the top of memory
    for (int t = 0; t < 300; t++) begin
      addr = ($urandom_range(0, 1) == 1) ? ('h1FC0 + int'($urandom_range(0, 63)))
                                         : int'($urandom_range(0, 63));
      size = ($urandom_range(0, 7) == 7) ? 2'b11 : 2'($urandom_range(0, 2));
      applyStimulus(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)),
                    addr, $urandom, 1'($urandom_range(0, 1)));
    end
    bus.req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
